inbuf_feed_ctrl: RTL and testbench

Sequencer for the bank of NROWS input FIFOs that feed one edge of the PE array.
- LOAD phase: takes one row-major operand stream over a valid/ready handshake and steers each word into the correct row FIFO.
- DRAIN phase: issues skewed read strobes so that row i starts popping i cycles after row 0, forming the diagonal wavefront the systolic array needs.
- Ends with a one-cycle completion pulse.

---
 rtl/systola_ctrl_pkg.sv | 18 +
 rtl/skew_rd_gen.sv | 31 +++
 rtl/inbuf_feed_ctrl.sv | 147 ++++++++++++++
 tb/tb_inbuf_feed_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systola_ctrl_pkg.sv
// Shared definitions for the systolic-array feed/drain controllers.
package systola_ctrl_pkg;

  // Job phases of a feed controller
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_t;

  // Counter width large enough to hold the longest drain cycle index
  // (MAXLEN+NROWS-2) plus one spare bit so out-of-range lengths stay visible.
  function automatic int calc_cntw(input int maxlen, input int nrows);
    return $clog2(maxlen + nrows) + 1;
  endfunction

endpackage

// File: rtl/skew_rd_gen.sv
// Skewed read-strobe decoder: row i pops for len_q cycles starting at t = i,
// producing the diagonal wavefront the systolic array expects.
module skew_rd_gen #(
  parameter int NROWS = 4,
  parameter int CNTW  = 6
) (
  input  logic              i_active,
  input  logic [CNTW-1:0]   i_t,
  input  logic [CNTW-1:0]   i_len_q,
  output logic [NROWS-1:0]  o_rd_en
);

  // Extend by one bit so i + len_q can never wrap
  logic [CNTW:0] w_t_ext;
  logic [CNTW:0] w_len_ext;

  assign w_t_ext   = {1'b0, i_t};
  assign w_len_ext = {1'b0, i_len_q};

  genvar gi;
  generate
    for (gi = 0; gi < NROWS; gi++) begin : g_row
      localparam logic [CNTW:0] ROW_IDX = (CNTW+1)'(gi);
      logic [CNTW:0] w_row_end;

      assign w_row_end   = ROW_IDX + w_len_ext;
      assign o_rd_en[gi] = i_active && (w_t_ext >= ROW_IDX) && (w_t_ext < w_row_end);
    end
  endgenerate

endmodule

// File: rtl/inbuf_feed_ctrl.sv
// Input-buffer feed controller: steers a row-major operand stream into NROWS
// row FIFOs, then drains them with skewed read strobes, then pulses done.
module inbuf_feed_ctrl
  import systola_ctrl_pkg::*;
#(
  parameter  int NROWS   = 4,
  parameter  int WORDLEN = 8,
  parameter  int MAXLEN  = 16,
  localparam int CNTW    = calc_cntw(MAXLEN, NROWS)
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic [CNTW-1:0]    i_len,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [WORDLEN-1:0] i_in_data,
  output logic [NROWS-1:0]   o_wr_en,
  output logic [WORDLEN-1:0] o_wr_data,
  output logic [NROWS-1:0]   o_rd_en,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int RW = (NROWS > 1) ? $clog2(NROWS) : 1;
  localparam logic [RW-1:0]   ROW_LAST  = RW'(NROWS - 1);
  localparam logic [CNTW-1:0] MAXLEN_C  = CNTW'(MAXLEN);
  localparam logic [CNTW-1:0] SKEW_TAIL = CNTW'(NROWS - 2);
  localparam logic [CNTW-1:0] ONE_C     = CNTW'(1);

  feed_state_t       r_state;
  logic [CNTW-1:0]   r_len_q;
  logic [CNTW-1:0]   r_col;
  logic [RW-1:0]     r_row;
  logic [CNTW-1:0]   r_t;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_len_ok;
  logic              w_col_last;
  logic [CNTW-1:0]   w_t_last;
  logic              w_drain_active;

  assign w_accept       = i_in_valid && r_in_ready;
  assign w_len_ok       = (i_len != '0) && (i_len <= MAXLEN_C);
  assign w_col_last     = (r_col == (r_len_q - ONE_C));
  assign w_t_last       = r_len_q + SKEW_TAIL;
  assign w_drain_active = (r_state == DRAIN);

  // Write strobe follows the accepted word in the same cycle, one-hot on the current row
  genvar gi;
  generate
    for (gi = 0; gi < NROWS; gi++) begin : g_wr
      assign o_wr_en[gi] = w_accept && (r_row == RW'(gi));
    end
  endgenerate

  assign o_wr_data  = i_in_data;
  assign o_in_ready = r_in_ready;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_err      = r_err;

  skew_rd_gen #(
    .NROWS (NROWS),
    .CNTW  (CNTW)
  ) u_skew_rd_gen (
    .i_active (w_drain_active),
    .i_t      (r_t),
    .i_len_q  (r_len_q),
    .o_rd_en  (o_rd_en)
  );

  // Job sequencer: phase transitions, row/col/cycle counters and registered status flags
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state    <= IDLE;
      r_len_q    <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_t        <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_len_q    <= i_len;
              r_col      <= '0;
              r_row      <= '0;
              r_t        <= '0;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            if (w_col_last) begin
              r_col <= '0;
              if (r_row == ROW_LAST) begin
                // Final word of the job: stop accepting and start draining
                r_in_ready <= 1'b0;
                r_t        <= '0;
                r_state    <= DRAIN;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + ONE_C;
            end
          end
        end
        DRAIN: begin
          if (r_t == w_t_last) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_t <= r_t + ONE_C;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inbuf_feed_ctrl.sv
// Self-checking bench for inbuf_feed_ctrl with a row-mapping / wavefront model.
module tb_inbuf_feed_ctrl;

  localparam int NROWS   = 4;
  localparam int WORDLEN = 8;
  localparam int MAXLEN  = 16;
  localparam int CNTW    = 6;

  logic               clk;
  logic               rstn;
  logic               start;
  logic [CNTW-1:0]    len;
  logic               in_valid;
  logic               in_ready;
  logic [WORDLEN-1:0] in_data;
  logic [NROWS-1:0]   wr_en;
  logic [WORDLEN-1:0] wr_data;
  logic [NROWS-1:0]   rd_en;
  logic               busy;
  logic               done;
  logic               err;

  int n_checks;
  int n_fail;

  inbuf_feed_ctrl #(
    .NROWS   (NROWS),
    .WORDLEN (WORDLEN),
    .MAXLEN  (MAXLEN)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_start    (start),
    .i_len      (len),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_in_data  (in_data),
    .o_wr_en    (wr_en),
    .o_wr_data  (wr_data),
    .o_rd_en    (rd_en),
    .o_busy     (busy),
    .o_done     (done),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Outputs must all be zero while in reset / idle
  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0;
    #3;
    n_checks++;
    if ({in_ready, wr_en, rd_en, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=0", {in_ready, wr_en, rd_en, busy, done, err});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, wr_en, rd_en, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_held got=%b exp=0", {in_ready, wr_en, rd_en, busy, done, err});
    end
    rstn = 1'b1;
    @(negedge clk);
    $display("reset released at %0t", $time);
  endtask

  // One full job. mode: 0 = valid always high with data=index, 1 = valid 1,0,1,0..,
  // 2 = random bubbles/data. poke: pulse start (len=2) in the middle of DRAIN.
  task automatic run_job(input int L, input int mode, input bit poke);
    int k;
    int cyc;
    int pops[NROWS];
    bit v;
    logic [NROWS-1:0]   exp_wr;
    logic [NROWS-1:0]   exp_rd;
    logic [WORDLEN-1:0] d;
    logic [CNTW-1:0]    lv;
    for (int i = 0; i < NROWS; i++) pops[i] = 0;
    lv = CNTW'(L);
    start = 1'b1; len = lv;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; cyc = 0;
    while (k < NROWS * L && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      d = (mode == 0) ? WORDLEN'(k) : WORDLEN'($urandom);
      in_valid = v; in_data = d;
      @(negedge clk);
      exp_wr = v ? (NROWS'(1) << (k / L)) : '0;
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1 || rd_en !== '0 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL load_status L=%0d k=%0d got ready=%b busy=%b rd=%b err=%b exp ready=1 busy=1 rd=0 err=0",
                 L, k, in_ready, busy, rd_en, err);
      end
      n_checks++;
      if (wr_en !== exp_wr) begin
        n_fail++;
        $display("FAIL load_wr_en L=%0d k=%0d got=%b exp=%b", L, k, wr_en, exp_wr);
      end
      if (v) begin
        n_checks++;
        if (wr_data !== d) begin
          n_fail++;
          $display("FAIL load_wr_data L=%0d k=%0d got=%h exp=%h", L, k, wr_data, d);
        end
        k++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (k != NROWS * L) begin
      n_fail++;
      $display("FAIL load_timeout L=%0d got=%0d words exp=%0d", L, k, NROWS * L);
    end
    for (int t = 0; t <= L + NROWS - 2; t++) begin
      if (poke && t == 2) begin
        start = 1'b1; len = CNTW'(2);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < NROWS; i++) exp_rd[i] = (t >= i) && (t < i + L);
      n_checks++;
      if (rd_en !== exp_rd) begin
        n_fail++;
        $display("FAIL drain_rd_en L=%0d t=%0d got=%b exp=%b", L, t, rd_en, exp_rd);
      end
      n_checks++;
      if (in_ready !== 1'b0 || wr_en !== '0 || done !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_status L=%0d t=%0d got ready=%b wr=%b done=%b busy=%b err=%b exp 0,0,0,1,0",
                 L, t, in_ready, wr_en, done, busy, err);
      end
      for (int i = 0; i < NROWS; i++) pops[i] += int'(rd_en[i]);
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b1 || rd_en !== '0) begin
      n_fail++;
      $display("FAIL done_pulse L=%0d got done=%b busy=%b rd=%b exp done=1 busy=1 rd=0", L, done, busy, rd_en);
    end
    for (int i = 0; i < NROWS; i++) begin
      n_checks++;
      if (pops[i] != L) begin
        n_fail++;
        $display("FAIL pop_count L=%0d row=%0d got=%0d exp=%0d", L, i, pops[i], L);
      end
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done L=%0d got done=%b busy=%b ready=%b exp 0,0,0", L, done, busy, in_ready);
    end
    $display("job len=%0d mode=%0d poke=%0d words=%0d at %0t", L, mode, poke, k, $time);
  endtask

  // Rejected start: err pulses one cycle, nothing else moves
  task automatic test_bad_len(input int L);
    start = 1'b1; len = CNTW'(L); in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || wr_en !== '0) begin
      n_fail++;
      $display("FAIL bad_len_err len=%0d got err=%b busy=%b ready=%b wr=%b exp 1,0,0,0", L, err, busy, in_ready, wr_en);
    end
    @(negedge clk);
    n_checks++;
    if (err !== 1'b0 || busy !== 1'b0 || wr_en !== '0) begin
      n_fail++;
      $display("FAIL bad_len_clear len=%0d got err=%b busy=%b wr=%b exp 0,0,0", L, err, busy, wr_en);
    end
    in_valid = 1'b0;
    $display("rejected start len=%0d", L);
  endtask

  // Reset in the middle of LOAD, then a fresh job from row 0
  task automatic test_midjob_reset();
    int k;
    start = 1'b1; len = CNTW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    k = 0;
    while (k < 5) begin
      in_data = WORDLEN'(k);
      @(negedge clk);
      n_checks++;
      if (wr_en !== (NROWS'(1) << (k / 3))) begin
        n_fail++;
        $display("FAIL prereset_wr_en k=%0d got=%b exp=%b", k, wr_en, NROWS'(1) << (k / 3));
      end
      k++;
      @(posedge clk); #1;
    end
    #1;
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({in_ready, wr_en, rd_en, busy, done, err} !== '0) begin
      n_fail++;
      $display("FAIL midjob_reset got=%b exp=0", {in_ready, wr_en, rd_en, busy, done, err});
    end
    in_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    $display("mid-job reset after %0d words", k);
    run_job(2, 0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    run_job(3, 0, 1'b0);
    run_job(3, 1, 1'b0);
    test_bad_len(0);
    test_bad_len(17);
    test_bad_len(int'($urandom_range(18, 63)));
    run_job(MAXLEN, 0, 1'b0);
    run_job(3, 2, 1'b1);
    for (int j = 0; j < 5; j++) begin
      run_job(int'($urandom_range(1, MAXLEN)), 2, j[0]);
    end
    run_job(1, 2, 1'b0);
    test_midjob_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
